// File: rtl/mem_arbiter.sv
// Fixed-latency sequencer sharing one single-port memory between the
// instruction-fetch and data-memory requesters; data side wins ties.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight, arbitrating dm_req over if_req
// BUSY_IF | fetch command issued, counting toward read latency
// BUSY_DM | data command issued, one cycle for writes, LATENCY for reads
// DONE_IF | if_ready pulse, requests ignored, back to IDLE
// DONE_DM | dm_ready pulse, requests ignored, back to IDLE
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall
);

  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_DM, DONE_IF, DONE_DM} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (dm_req) begin
          state_d     = BUSY_DM;
          cnt_d       = 4'd1;
          mem_en_d    = 1'b1;
          mem_addr_d  = dm_addr;
          mem_we_d    = dm_we;
          mem_be_d    = dm_we ? dm_be : 4'd0;
          mem_wdata_d = dm_we ? dm_wdata : 32'd0;
        end else if (if_req) begin
          state_d     = BUSY_IF;
          cnt_d       = 4'd1;
          mem_en_d    = 1'b1;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'd0;
          mem_wdata_d = 32'd0;
        end
      end

      BUSY_IF: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAT_CNT) begin
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          state_d    = DONE_IF;
          cnt_d      = 4'd0;
        end
      end

      BUSY_DM: begin
        cnt_d = cnt_q + 4'd1;
        // Writes retire after the strobe cycle and leave dm_rdata alone.
        if (mem_we_q) begin
          if (cnt_q == 4'd1) begin
            dm_ready_d = 1'b1;
            state_d    = DONE_DM;
            cnt_d      = 4'd0;
          end
        end else if (cnt_q == LAT_CNT) begin
          dm_rdata_d = mem_rdata;
          dm_ready_d = 1'b1;
          state_d    = DONE_DM;
          cnt_d      = 4'd0;
        end
      end

      DONE_IF, DONE_DM: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;

  // Combinational so the pipeline freezes in the same cycle a request appears.
  assign stall = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-exact timing checks plus a read-data
// scoreboard popped on every ready pulse, against a behavioural memory.
module tb_mem_arbiter;
  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              stall;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_be    (dm_be),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall    (stall)
  );

  // Memory model: data valid only in the cycle LATENCY-1 after the strobe cycle.
  logic [31:0] mem [0:1023];
  logic        init_done = 1'b0;
  logic        rvld = 1'b0;
  logic [31:0] rdat = 32'd0;

  always @(posedge clk) begin
    if (!init_done) begin
      mem[10'h004] <= 32'h2402000A;
      mem[10'h008] <= 32'h11112222;
      mem[10'h010] <= 32'h33334444;
      mem[10'h0FF] <= 32'h55556666;
      init_done    <= 1'b1;
    end
    rvld <= mem_en & ~mem_we;
    rdat <= mem[mem_addr];
    if (mem_en & mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  assign mem_rdata = (rvld === 1'b1) ? rdat : 32'hBAD0BAD0;

  int checks = 0;
  int errors = 0;
  int if_pulses = 0;
  int dm_pulses = 0;
  int spurious = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next sample point and score any completion seen there.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (if_ready === 1'b1) begin
      if_pulses++;
      if (if_q.size() > 0) chk("if_rdata_sb", if_rdata, if_q.pop_front());
      else spurious++;
    end
    if (dm_ready === 1'b1) begin
      dm_pulses++;
      if (dm_q.size() > 0) chk("dm_rdata_sb", dm_rdata, dm_q.pop_front());
      else spurious++;
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_if_ready"},  32'(if_ready),  32'd0);
    chk({pfx, "_dm_ready"},  32'(dm_ready),  32'd0);
    chk({pfx, "_mem_en"},    32'(mem_en),    32'd0);
    chk({pfx, "_mem_we"},    32'(mem_we),    32'd0);
    chk({pfx, "_mem_be"},    32'(mem_be),    32'd0);
    chk({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({pfx, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({pfx, "_if_rdata"},  if_rdata,       32'd0);
    chk({pfx, "_dm_rdata"},  dm_rdata,       32'd0);
  endtask

  initial begin
    int n;
    logic found;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_be = 4'd0; dm_addr = '0; dm_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk("reset_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    step();

    // IF read at 0x004, address changed after the grant edge.
    if_req = 1'b1; if_addr = 10'h004; if_q.push_back(32'h2402000A);
    #1 chk("a_c0_stall", 32'(stall), 32'd1);
    step();
    chk("a_c1_mem_en", 32'(mem_en), 32'd1);
    chk("a_c1_mem_addr", 32'(mem_addr), 32'h004);
    chk("a_c1_mem_we", 32'(mem_we), 32'd0);
    chk("a_c1_stall", 32'(stall), 32'd1);
    if_addr = 10'h0FF;
    step();
    chk("a_c2_mem_en", 32'(mem_en), 32'd0);
    chk("a_c2_mem_addr", 32'(mem_addr), 32'h004);
    chk("a_c2_if_ready", 32'(if_ready), 32'd0);
    chk("a_c2_stall", 32'(stall), 32'd1);
    step();
    chk("a_c3_if_ready", 32'(if_ready), 32'd1);
    chk("a_c3_stall", 32'(stall), 32'd0);
    if_req = 1'b0;
    step();
    chk("a_c4_if_ready", 32'(if_ready), 32'd0);
    chk("a_c4_if_rdata_hold", if_rdata, 32'h2402000A);

    // Simultaneous DM read 0x010 and IF read 0x008.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010; dm_q.push_back(32'h33334444);
    if_req = 1'b1; if_addr = 10'h008; if_q.push_back(32'h11112222);
    step();
    chk("b_c1_mem_en", 32'(mem_en), 32'd1);
    chk("b_c1_mem_addr", 32'(mem_addr), 32'h010);
    step();
    chk("b_c2_mem_en", 32'(mem_en), 32'd0);
    step();
    chk("b_c3_dm_ready", 32'(dm_ready), 32'd1);
    chk("b_c3_if_ready", 32'(if_ready), 32'd0);
    dm_req = 1'b0;
    #1 chk("b_c3_stall", 32'(stall), 32'd1);
    step();
    chk("b_c4_mem_en", 32'(mem_en), 32'd0);
    chk("b_c4_dm_ready", 32'(dm_ready), 32'd0);
    step();
    chk("b_c5_mem_en", 32'(mem_en), 32'd1);
    chk("b_c5_mem_addr", 32'(mem_addr), 32'h008);
    step();
    chk("b_c6_if_ready", 32'(if_ready), 32'd0);
    step();
    chk("b_c7_if_ready", 32'(if_ready), 32'd1);
    if_req = 1'b0;
    step();

    // DM partial write; dm_rdata must keep the previous load value.
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 10'h010;
    dm_wdata = 32'hDEADBEEF; dm_q.push_back(32'h33334444);
    step();
    chk("c_c1_mem_en", 32'(mem_en), 32'd1);
    chk("c_c1_mem_we", 32'(mem_we), 32'd1);
    chk("c_c1_mem_be", 32'(mem_be), 32'h3);
    chk("c_c1_mem_addr", 32'(mem_addr), 32'h010);
    chk("c_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("c_c2_dm_ready", 32'(dm_ready), 32'd1);
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'd0; dm_wdata = 32'd0;
    step();
    chk("c_c3_dm_ready", 32'(dm_ready), 32'd0);

    // IF read right after a write: command fields forced to zero.
    if_req = 1'b1; if_addr = 10'h0FF; if_q.push_back(32'h55556666);
    step();
    chk("e_c1_mem_en", 32'(mem_en), 32'd1);
    chk("e_c1_mem_addr", 32'(mem_addr), 32'h0FF);
    chk("e_c1_mem_we", 32'(mem_we), 32'd0);
    chk("e_c1_mem_be", 32'(mem_be), 32'd0);
    chk("e_c1_mem_wdata", mem_wdata, 32'd0);
    step();
    step();
    chk("e_c3_if_ready", 32'(if_ready), 32'd1);
    if_req = 1'b0;
    step();

    // Read back the merged word.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010; dm_q.push_back(32'h3333BEEF);
    step();
    step();
    step();
    chk("d_c3_dm_ready", 32'(dm_ready), 32'd1);
    dm_req = 1'b0;
    step();

    // Reset pulsed in cycle 2 of an IF read with if_req held.
    if_req = 1'b1; if_addr = 10'h004;
    step();
    step();
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    chk("midrst_stall", 32'(stall), 32'd1);
    step();
    rst = 1'b0;
    if_q.push_back(32'h2402000A);
    chk("f_c3_mem_en", 32'(mem_en), 32'd0);
    chk("f_c3_if_ready", 32'(if_ready), 32'd0);
    step();
    chk("f_c4_mem_en", 32'(mem_en), 32'd1);
    chk("f_c4_mem_addr", 32'(mem_addr), 32'h004);
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      n++;
      if (if_ready === 1'b1) found = 1'b1;
    end
    chk("f_ready_seen", 32'(found), 32'd1);
    chk("f_ready_latency", 32'(n), 32'd2);
    if_req = 1'b0;
    step();
    step();

    chk("spurious_ready", 32'(spurious), 32'd0);
    chk("if_pulse_count", 32'(if_pulses), 32'd4);
    chk("dm_pulse_count", 32'(dm_pulses), 32'd3);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified instruction/data memory between the pipeline's instruction-fetch port (IF) and data-memory port (MEM stage). It replaces the separate instruction and data memories with one shared array behind a fixed-latency access sequencer. Each requester gets a request/ready handshake. A global `stall` tells the pipeline registers to freeze until every outstanding access has completed.

## Interface
- `ADDR_W`, default 10: word-address width.
- `LATENCY`, default 2: memory read latency in cycles. Legal range is 1..15.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request; held until `if_ready`
- `if_addr`  in  ADDR_W  fetch word address
- `if_rdata`  out  32  fetched instruction; holds its value until the next IF completion
- `if_ready`  out  1  one-cycle completion pulse for IF
- `dm_req`  in  1  data request; held until `dm_ready`
- `dm_we`  in  1  1 = write, 0 = read
- `dm_be`  in  4  byte enables for writes
- `dm_addr`  in  ADDR_W  data word address
- `dm_wdata`  in  32  write data
- `dm_rdata`  out  32  load data; holds its value until the next DM read completion
- `dm_ready`  out  1  one-cycle completion pulse for DM
- `mem_en`  out  1  memory access strobe, exactly one cycle per access
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/4/ADDR_W/32  memory command
- `mem_rdata`  in  32  memory read data, valid LATENCY cycles after the `mem_en` cycle began
- `stall`  out  1  pipeline freeze

## Operation
- **States:** IDLE, BUSY_IF, BUSY_DM, DONE_IF, DONE_DM. Reset state is IDLE.
- **Arbitration (IDLE only):**
  - `dm_req` has priority over `if_req`, because the MEM-stage instruction is older.
  - If neither is requesting, remain in IDLE.
- **Grant edge:**
  - Latch the winner's addr/we/be/wdata into command registers.
  - Go to BUSY_x with `cnt` = 1.
  - `mem_en` is high only in the first BUSY cycle. `mem_we`/`mem_be`/`mem_wdata` are forced to 0 for IF and for DM reads.
- **BUSY_x:** `cnt` increments every cycle. The access finishes at the end of the BUSY cycle in which:
  - reads: `cnt` == LATENCY; capture `mem_rdata` into `x_rdata`.
  - writes: `cnt` == 1; `dm_rdata` is unchanged.
- **Completion:** the state moves to DONE_x.
- **DONE_x:**
  - `x_ready` = 1 for exactly this cycle.
  - Next state is IDLE unconditionally, and requests are ignored during DONE. The held request is consumed at this edge, and the requester presents its next request from the following cycle.
- **Stability:** requester inputs that change after the grant edge are ignored, because the command is latched.
- **Stall:** `stall` = (`if_req` & ~`if_ready`) | (`dm_req` & ~`dm_ready`). It is combinational from the inputs and the registered ready signals.
- **Dropped request:** a requester that drops `req` while it is being served is a protocol violation. The access still completes and the ready pulse is still issued.
- **Reset mid-access:**
  - The FSM returns to IDLE and `cnt` clears.
  - All outputs go to 0, including `if_rdata` and `dm_rdata`.
  - The in-flight access is abandoned with no ready pulse. A write whose `mem_en` cycle has already passed is not undone.

## Timing
- All outputs are registered except `stall`. Reset values are 0 for every output.
- With the request first seen in cycle 0 while in IDLE:
  - `mem_en` in cycle 1.
  - Read data present in cycle LATENCY.
  - Ready in cycle LATENCY+1.
  - IDLE again in cycle LATENCY+2.
- Write: `mem_en` in cycle 1 and ready in cycle 2.
- Throughput is one read per LATENCY+2 cycles and one write per 3 cycles.
- With both requesters asserted in cycle 0 (DM read), IF is granted at the end of cycle LATENCY+2, giving `if_ready` in cycle 2·LATENCY+3.
- `stall` is high for every cycle from request to ready, exclusive of the ready cycle.

## Test plan
- **Reset:** assert `rst` asynchronously between edges -> all outputs read 0 immediately; FSM is in IDLE after release.
- **IF read, LATENCY=2:**
  - Stimulus: `if_req`, addr 0x004; memory returns 0x2402000A.
  - Required: `mem_en`=1 with `mem_addr`=0x004 and `mem_we`=0 in cycle 1.
  - Required: `if_ready`=1 and `if_rdata`=0x2402000A in cycle 3.
  - Required: `stall` high in cycles 0-2 and low in cycle 3.
- **Simultaneous requests:**
  - Stimulus: `dm_req` read at 0x010 and `if_req` at 0x008, both in cycle 0.
  - Required: DM `mem_en` in cycle 1 and `dm_ready` in cycle 3.
  - Required: IF `mem_en` in cycle 5 and `if_ready` in cycle 7.
- **DM write:**
  - Stimulus: `dm_we`=1, `dm_be`=4'b0011, addr 0x010, wdata 0xDEADBEEF.
  - Required: in cycle 1, `mem_en`=1, `mem_we`=1, and `mem_be`/`mem_addr`/`mem_wdata` carry those values.
  - Required: `dm_ready` in cycle 2; `dm_rdata` keeps its prior value.
- **Input change after grant:** change `if_addr` from 0x004 to 0x0FF in cycle 1 -> `mem_addr` stays 0x004 and the completion returns the 0x004 data.
- **Reset mid-read:**
  - Stimulus: `rst` pulsed in cycle 2 of an IF read; `if_req` kept high.
  - Required: no `if_ready` pulse.
  - Required: after release, a new `mem_en` occurs on the cycle after the first IDLE edge, followed by normal completion.
